// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: requester identity,
// arbiter FSM state and the lock-counter width helper.
package mem_arb_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_AUX = 1'b1
    } req_e;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Counter must hold LOCK_MAX-1; keep at least one bit for tiny windows.
    function automatic int lock_cnt_w(input int lock_max);
        return (lock_max <= 2) ? 1 : $clog2(lock_max);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (cpu/aux) handshakes and the memory-side bus.
// aux_lock exists only when MEM_ARB_LOCK_EN is defined.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              aux_req;
    logic              aux_we;
    logic [ADDR_W-1:0] aux_addr;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_gnt;
    logic              aux_stall;
    logic              aux_rvalid;
    logic [DATA_W-1:0] aux_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic              aux_lock;
`endif

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  aux_lock,
`endif
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  aux_req, aux_we, aux_addr, aux_wdata,
        output aux_gnt, aux_stall, aux_rvalid, aux_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / memory environment side
    modport master (
`ifdef MEM_ARB_LOCK_EN
        output aux_lock,
`endif
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output aux_req, aux_we, aux_addr, aux_wdata,
        input  aux_gnt, aux_stall, aux_rvalid, aux_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// a contest goes to whichever side did not own the memory last.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_e       last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_owner == REQ_CPU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data BRAM between the core and the aux
// master, one access per cycle. Define MEM_ARB_LOCK_EN for aux exclusive lock.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    logic [1:0]        req;
    logic [1:0]        pick;
    req_e              last_owner;
    logic              cpu_gnt;
    logic              aux_gnt;
    logic              force_rel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              vld_p1;
    req_e              owner_p1;

    assign req = {bus.aux_req, bus.cpu_req};

    arb_rr2 u_rr (
        .req        (req),
        .last_owner (last_owner),
        .gnt        (pick)
    );

`ifdef MEM_ARB_LOCK_EN
    localparam int CNT_W = lock_cnt_w(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             lock_armed;

    assign cnt_inc   = lock_cnt + CNT_W'(1);
    assign force_rel = (state == ARB_LOCKED) && bus.aux_lock && (cnt_inc == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARB_NORMAL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_NORMAL: if (aux_gnt && bus.aux_lock && lock_armed) state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (!bus.aux_lock || force_rel)            state_nxt = ARB_NORMAL;
            default:    state_nxt = ARB_NORMAL;
        endcase
    end

    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (!reset) begin
            if (state == ARB_LOCKED) begin
                aux_gnt = bus.aux_req;
            end else begin
                cpu_gnt = pick[0];
                aux_gnt = pick[1];
            end
        end
    end

    // After a forced release aux must drop aux_lock before it may lock again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt   <= '0;
            lock_armed <= 1'b1;
        end else begin
            lock_cnt <= (state == ARB_LOCKED && state_nxt == ARB_LOCKED) ? cnt_inc : '0;
            if (force_rel)          lock_armed <= 1'b0;
            else if (!bus.aux_lock) lock_armed <= 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
    assign cpu_gnt   = pick[0] & ~reset;
    assign aux_gnt   = pick[1] & ~reset;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          last_owner <= REQ_AUX;
        else if (force_rel) last_owner <= REQ_AUX;
        else if (cpu_gnt)   last_owner <= REQ_CPU;
        else if (aux_gnt)   last_owner <= REQ_AUX;
    end

    assign addr_sel  = aux_gnt ? bus.aux_addr  : bus.cpu_addr;
    assign wdata_sel = aux_gnt ? bus.aux_wdata : bus.cpu_wdata;

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.aux_gnt   = aux_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;
    assign bus.aux_stall = bus.aux_req & ~aux_gnt;
    assign bus.mem_en    = cpu_gnt | aux_gnt;
    assign bus.mem_we    = (cpu_gnt & bus.cpu_we) | (aux_gnt & bus.aux_we);
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = wdata_sel;

    // Stage p1: BRAM read data returns; steer it to the requester that issued it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            owner_p1 <= REQ_CPU;
        end else begin
            vld_p1   <= bus.mem_en & ~bus.mem_we;
            owner_p1 <= aux_gnt ? REQ_AUX : REQ_CPU;
        end
    end

    assign bus.cpu_rvalid = vld_p1 & (owner_p1 == REQ_CPU);
    assign bus.aux_rvalid = vld_p1 & (owner_p1 == REQ_AUX);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
    assign bus.aux_rdata  = bus.aux_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a request-level reference model
// with a 16-word BRAM; lock scenarios run when MEM_ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;

    localparam int LOCK_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory with one-cycle registered read
    logic [31:0] bram [16];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) bram[bus.mem_addr[5:2]] <= bus.mem_wdata;
            else            bus.mem_rdata <= bram[bus.mem_addr[5:2]];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] shadow [16];
    int          m_last;      // 0 = cpu owned last, 1 = aux
    bit          m_pend;
    int          m_owner;
    logic [31:0] m_data;
    bit          m_locked;
    int          m_lc;
    bit          m_armed;

    // Observations from the latest cycle, for directed checks
    bit          rec_cg, rec_ag, rec_cs, rec_as, rec_crv, rec_arv, rec_we;
    logic [31:0] rec_crd;

    function automatic bit lock_in();
`ifdef MEM_ARB_LOCK_EN
        return bus.aux_lock;
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_lock(input bit v);
`ifdef MEM_ARB_LOCK_EN
        bus.aux_lock = v;
`else
        if (v) $display("note: lock request ignored in this build");
`endif
    endtask

    task automatic model_check();
        bit ec, ea, wwe;
        logic [31:0] wad, wwd;
        bit lk;
        lk = lock_in();
        if (reset) begin
            m_pend = 0; m_last = 1; m_locked = 0; m_lc = 0; m_armed = 1;
        end
        if (reset) begin
            ec = 0; ea = 0;
        end else if (m_locked) begin
            ec = 0; ea = bus.aux_req;
        end else if (bus.cpu_req && bus.aux_req) begin
            ec = (m_last == 1); ea = !ec;
        end else begin
            ec = bus.cpu_req; ea = bus.aux_req;
        end
        wwe = ea ? bus.aux_we : bus.cpu_we;
        wad = ea ? bus.aux_addr : bus.cpu_addr;
        wwd = ea ? bus.aux_wdata : bus.cpu_wdata;

        check_val("cpu_gnt", bus.cpu_gnt, ec);
        check_val("aux_gnt", bus.aux_gnt, ea);
        check_val("cpu_stall", bus.cpu_stall, bus.cpu_req && !ec);
        check_val("mem_en", bus.mem_en, ec || ea);
        check_val("mem_we", bus.mem_we, (ec || ea) && wwe);
        if (ec || ea) begin
            check_val("mem_addr", bus.mem_addr, wad);
            if (wwe) check_val("mem_wdata", bus.mem_wdata, wwd);
        end
        check_val("cpu_rvalid", bus.cpu_rvalid, m_pend && m_owner == 0);
        check_val("aux_rvalid", bus.aux_rvalid, m_pend && m_owner == 1);
        check_val("cpu_rdata", bus.cpu_rdata, (m_pend && m_owner == 0) ? m_data : 32'h0);
        check_val("aux_rdata", bus.aux_rdata, (m_pend && m_owner == 1) ? m_data : 32'h0);

        rec_cg = bus.cpu_gnt; rec_ag = bus.aux_gnt; rec_cs = bus.cpu_stall;
        rec_as = bus.aux_stall; rec_crv = bus.cpu_rvalid; rec_arv = bus.aux_rvalid;
        rec_we = bus.mem_we; rec_crd = bus.cpu_rdata;

        if (reset) return;
        m_pend = (ec || ea) && !wwe;
        m_owner = ea ? 1 : 0;
        m_data = shadow[wad[5:2]];
        if ((ec || ea) && wwe) shadow[wad[5:2]] = wwd;
        if (ec) m_last = 0;
        if (ea) m_last = 1;
        if (m_locked) begin
            m_lc++;
            if (!lk) m_locked = 0;
            else if (m_lc == LOCK_MAX) begin
                m_locked = 0; m_last = 1; m_armed = 0;
            end
        end else if (ea && lk && m_armed) begin
            m_locked = 1; m_lc = 1;
        end
        if (!lk) m_armed = 1;
    endtask

    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.cpu_req = 0; bus.aux_req = 0; bus.cpu_we = 0; bus.aux_we = 0;
    endtask

    task automatic do_reset();
        idle();
        set_lock(0);
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic new_cpu();
        bus.cpu_req   = ($urandom_range(0, 3) != 0);
        bus.cpu_we    = $urandom_range(0, 1);
        bus.cpu_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.cpu_wdata = $urandom;
    endtask

    task automatic new_aux();
        bus.aux_req   = ($urandom_range(0, 3) != 0);
        bus.aux_we    = $urandom_range(0, 1);
        bus.aux_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.aux_wdata = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit exp_ag [12] = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 1};
        bit lk_pat [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1};
        for (int i = 0; i < 16; i++) begin
            shadow[i] = (i == 4) ? 32'hDEADBEEF : $urandom;
            bram[i] <= shadow[i];
        end
        bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.aux_addr = 0; bus.aux_wdata = 0;
        idle();
        set_lock(0);
        m_last = 1; m_pend = 0; m_owner = 0; m_data = 0;
        m_locked = 0; m_lc = 0; m_armed = 1;

        // Requests held during reset must not be granted
        reset = 1;
        bus.cpu_req = 1; bus.aux_req = 1;
        @(posedge clk); #1;
        step();
        check_val("rst_cpu_gnt", rec_cg, 0);
        check_val("rst_aux_gnt", rec_ag, 0);
        reset = 0;
        idle();
        step();

        // Single cpu read of 0x10
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        step();
        check_val("t1_gnt", rec_cg, 1);
        check_val("t1_stall", rec_cs, 0);
        idle();
        step();
        check_val("t1_rvalid", rec_crv, 1);
        check_val("t1_rdata", rec_crd, 32'hDEADBEEF);

        // Contention alternates starting with cpu
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h4;
            bus.aux_req = 1; bus.aux_we = 0; bus.aux_addr = 32'h8;
            step();
            check_val($sformatf("t2_cpu_gnt%0d", i), rec_cg, (i % 2) == 0);
            check_val($sformatf("t2_stall%0d", i), rec_cs, (i % 2) == 1);
        end
        idle();
        step();

        // aux write then cpu read of the same word
        bus.aux_req = 1; bus.aux_we = 1; bus.aux_addr = 32'h20; bus.aux_wdata = 32'h55;
        step();
        check_val("t3_we", rec_we, 1);
        idle();
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h20;
        step();
        check_val("t3_rd_we", rec_we, 0);
        check_val("t3_no_aux_rvalid", rec_arv, 0);
        idle();
        step();
        check_val("t3_rdata", rec_crd, 32'h55);

        // Reset during an in-flight read drops the response
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h10;
        step();
        idle();
        reset = 1;
        step();
        check_val("t5_rvalid_rst", rec_crv, 0);
        reset = 0;
        step();
        check_val("t5_rvalid_after", rec_crv, 0);
        bus.cpu_req = 1; bus.aux_req = 1; bus.cpu_we = 0; bus.aux_we = 0;
        step();
        check_val("t5_first_contest", rec_cg, 1);
        idle();
        step();

`ifdef MEM_ARB_LOCK_EN
        // Lock window of LOCK_MAX grants, then forced release and re-arm
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'hC;
            bus.aux_req = 1; bus.aux_we = 0; bus.aux_addr = 32'h18;
            set_lock(lk_pat[i]);
            step();
            check_val($sformatf("t4_aux_gnt%0d", i), rec_ag, exp_ag[i]);
        end
        set_lock(0);
        idle();
        step();
`else
        if (exp_ag[0] != lk_pat[0]) check_val("t4_skipped", rec_ag, rec_ag);
`endif

        // Randomized traffic with occasional reset and drops
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!bus.cpu_req || rec_cg) new_cpu();
            else if ($urandom_range(0, 19) == 0) bus.cpu_req = 0;
            if (!bus.aux_req || rec_ag) new_aux();
            else if ($urandom_range(0, 19) == 0) bus.aux_req = 0;
            if ($urandom_range(0, 7) == 0) set_lock(!lock_in());
            step();
        end
        reset = 0;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port unified instruction/data memory between the multi-cycle RISC-V core and an auxiliary master (program loader/debug port). It sits between the datapath's memory address/write-data path and the BRAM. It issues at most one access per cycle, routes 1-cycle-latency read data back to the owning requester, and gives the core controller a stall signal so its FSM holds state while the memory is busy.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width
- LOCK_MAX, 16, max consecutive locked cycles before forced release (only used with MEM_ARB_LOCK_EN)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- cpu_req  in  1  core access request; held with address/data until granted
- cpu_we  in  1  core write enable
- cpu_addr  in  ADDR_W  core address
- cpu_wdata  in  DATA_W  core write data
- cpu_gnt  out  1  access accepted this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- cpu_rvalid  out  1  read data valid (cycle after read grant)
- cpu_rdata  out  DATA_W  read data
- aux_req, aux_we, aux_addr, aux_wdata, aux_gnt, aux_rvalid, aux_rdata: same as cpu_* for auxiliary master
- aux_lock  in  1  aux requests exclusive ownership (MEM_ARB_LOCK_EN only)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en & ~mem_we

## Operation
- Grant is combinational from current req and registered state; winner's we/addr/wdata drive mem_*; mem_en = cpu_gnt | aux_gnt. gnt_cpu and gnt_aux never both 1.
- Single requester: granted every cycle it requests (back-to-back allowed).
- Both requesting: round-robin; winner is the one not granted most recently (last_owner register, updated on every grant).
- Reads: owner register captured at grant; next cycle the owner's rvalid=1, rdata=mem_rdata. Non-owner rdata driven 0. Writes produce no rvalid.
- A read response and a new grant may occur in the same cycle (fully pipelined, 1 access/cycle).
- Lock (with MEM_ARB_LOCK_EN): FSM states ARB (normal) and LOCKED. ARB -> LOCKED when aux_gnt & aux_lock. In LOCKED: cpu never granted, aux granted whenever aux_req; lock counter increments each cycle. LOCKED -> ARB when aux_lock=0 or counter reaches LOCK_MAX-1; on forced release last_owner=aux so cpu wins the next contended cycle, and aux_lock must drop and re-rise before re-locking.

## Timing
- Reset values: all gnt/rvalid/mem_en/mem_we 0, rdata 0, last_owner=aux (cpu wins first contest), state ARB, lock counter 0.
- While reset asserted, grants and mem_en forced 0 combinationally.
- Read latency: grant in cycle N -> rvalid in cycle N+1.
- Reset asserted with a read in flight: response dropped; no rvalid after reset release.
- Requester dropping req without a grant is legal; no state changes.

## Configuration
- MEM_ARB_LOCK_EN defined: aux_lock port present, ARB/LOCKED FSM and LOCK_MAX counter built.
- Undefined: aux_lock port absent, pure round-robin, LOCK_MAX ignored.

## Structure
- Package mem_arb_pkg: requester enum (REQ_CPU, REQ_AUX), arbiter state enum (ARB_NORMAL, ARB_LOCKED), lock-counter width derived from LOCK_MAX.
- One sub-module: arb_rr2, combinational 2-way round-robin picker (req[1:0], last_owner -> gnt[1:0]).

## Test plan
- cpu_req only, read addr 0x10 with mem holding 0xDEADBEEF -> cpu_gnt same cycle, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF next cycle, cpu_stall=0.
- Both req every cycle for 6 cycles after reset -> grants alternate cpu,aux,cpu,aux,cpu,aux; cpu_stall=1 on aux cycles.
- aux write 0x55 to 0x20 then cpu read 0x20 next cycle -> mem_we=1 once, cpu_rdata=0x55, no aux_rvalid.
- Lock build, LOCK_MAX=4, aux_lock and both req held -> aux granted 4 cycles, then cpu granted; aux not re-locked until aux_lock toggles.
- Reset pulse in cycle after cpu read grant -> cpu_rvalid stays 0, first post-reset contest won by cpu.
